// File: rtl/cpu_regs_pkg.sv
// Shared encodings for the CPU register file: store targets, PC/SP operations
// and status-register bit positions.
package cpu_regs_pkg;

  typedef enum logic [3:0] {
    ST_NONE = 4'd0,
    ST_GPR  = 4'd1,
    ST_PCH  = 4'd2,
    ST_PCL  = 4'd3,
    ST_P    = 4'd4,
    ST_ADL  = 4'd5,
    ST_ADH  = 4'd6,
    ST_BAL  = 4'd7,
    ST_BAH  = 4'd8,
    ST_IR   = 4'd9,
    ST_IMM  = 4'd10,
    ST_OFF  = 4'd11
  } st_sel_t;

  typedef enum logic [1:0] {
    PC_HOLD    = 2'd0,
    PC_INC     = 2'd1,
    PC_LOAD_AD = 2'd2,
    PC_REL     = 2'd3
  } pc_op_t;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2,
    SP_LOAD = 2'd3
  } sp_op_t;

  localparam int N_BIT = 7;
  localparam int V_BIT = 6;
  localparam int U_BIT = 5;
  localparam int B_BIT = 4;
  localparam int D_BIT = 3;
  localparam int I_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int C_BIT = 0;

  localparam logic [7:0] STATUS_RESET = 8'h24;

endpackage

// File: rtl/byte_pair_reg.sv
// Two-byte pointer register with per-byte loads, +1 with carry across the
// full width, and a high-byte clear that overrides everything else.
module byte_pair_reg #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic                  inc,
  input  logic                  clr_hi,
  input  logic [DATA_W-1:0]     data_in,
  output logic [2*DATA_W-1:0]   q
);

  logic [2*DATA_W-1:0] bumped;
  logic [2*DATA_W-1:0] q_next;

  // Byte stores land on top of the incremented value; the clear is applied last.
  always_comb begin
    bumped = inc ? q + (2*DATA_W)'(1) : q;
    q_next = bumped;
    if (wr_lo) q_next[DATA_W-1:0] = data_in;
    if (wr_hi) q_next[2*DATA_W-1:DATA_W] = data_in;
    if (clr_hi) q_next[2*DATA_W-1:DATA_W] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else if (!hold) q <= q_next;
  end

endmodule

// File: rtl/cpu_regfile_param.sv
// Parametrised CPU register file: GPRs, IR/IMM/OFFSET, SP, PC, AD/BA pointers
// and the P status register, all updated at the clock edge under sequencer control.
module cpu_regfile_param
  import cpu_regs_pkg::*;
#(
  parameter int                  DATA_W     = 8,
  parameter int                  NUM_GPR    = 3,
  parameter logic [DATA_W-1:0]   SP_RESET   = 8'hFD,
  parameter logic [2*DATA_W-1:0] PC_RESET   = 16'hFFFC,
  parameter logic [DATA_W-1:0]   STACK_PAGE = 8'h01,
  localparam int ADDR_W = 2*DATA_W,
  localparam int IDX_W  = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [3:0]                st_sel,
  input  logic [IDX_W-1:0]          st_idx,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      alu_we,
  input  logic [IDX_W-1:0]          alu_idx,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic [1:0]                pc_op,
  input  logic [1:0]                sp_op,
  input  logic                      ad_inc,
  input  logic                      clr_adh,
  input  logic                      clr_bah,
  input  logic [7:0]                next_status,
  input  logic [7:0]                status_mask,
  output logic [NUM_GPR*DATA_W-1:0] gpr,
  output logic [DATA_W-1:0]         ir,
  output logic [DATA_W-1:0]         imm,
  output logic [DATA_W-1:0]         offset,
  output logic [DATA_W-1:0]         sp,
  output logic [ADDR_W-1:0]         pc,
  output logic [ADDR_W-1:0]         ad,
  output logic [ADDR_W-1:0]         ba,
  output logic [ADDR_W-1:0]         stack_addr,
  output logic [7:0]                status,
  output logic                      n,
  output logic                      v,
  output logic                      b,
  output logic                      d,
  output logic                      i,
  output logic                      z,
  output logic                      c,
  output logic                      page_cross
);

  logic [DATA_W-1:0] gpr_q    [NUM_GPR];
  logic [DATA_W-1:0] gpr_next [NUM_GPR];
  logic [ADDR_W-1:0] pc_full;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] pcl_half;
  logic [DATA_W-1:0] pch_half;
  logic [DATA_W-1:0] sp_next;
  logic [7:0]        status_next;
  logic              page_cross_next;

  // ALU writeback beats a bus store to the same GPR; out-of-range indices match nothing.
  always_comb begin
    for (int k = 0; k < NUM_GPR; k++) begin
      gpr_next[k] = gpr_q[k];
      if (alu_we && alu_idx == IDX_W'(k)) gpr_next[k] = alu_out;
      else if (st_sel == ST_GPR && st_idx == IDX_W'(k)) gpr_next[k] = data_in;
    end
  end

  // A byte store to PC keeps the other half's own result, computed without inter-byte carry.
  always_comb begin
    pc_full  = pc;
    pcl_half = pc[DATA_W-1:0];
    pch_half = pc[ADDR_W-1:DATA_W];
    case (pc_op)
      PC_INC: begin
        pc_full  = pc + ADDR_W'(1);
        pcl_half = pc[DATA_W-1:0] + DATA_W'(1);
      end
      PC_LOAD_AD: begin
        pc_full  = ad;
        pcl_half = ad[DATA_W-1:0];
        pch_half = ad[ADDR_W-1:DATA_W];
      end
      PC_REL: begin
        pc_full  = pc + {{DATA_W{offset[DATA_W-1]}}, offset};
        pcl_half = pc[DATA_W-1:0] + offset;
        pch_half = pc[ADDR_W-1:DATA_W] + {DATA_W{offset[DATA_W-1]}};
      end
      default: ;
    endcase
    pc_next = pc_full;
    if (st_sel == ST_PCH) pc_next = {data_in, pcl_half};
    else if (st_sel == ST_PCL) pc_next = {pch_half, data_in};
    page_cross_next = (pc_op == PC_REL) && (pc_next[ADDR_W-1:DATA_W] != pc[ADDR_W-1:DATA_W]);
  end

  always_comb begin
    sp_next = sp;
    case (sp_op)
      SP_PUSH: sp_next = sp - DATA_W'(1);
      SP_POP:  sp_next = sp + DATA_W'(1);
      SP_LOAD: sp_next = data_in;
      default: ;
    endcase
  end

  // Bus store to P never touches B; the mask still governs B when both happen.
  always_comb begin
    status_next = status;
    for (int k = 0; k < 8; k++) begin
      if (st_sel == ST_P && k != B_BIT && k != U_BIT) status_next[k] = data_in[k];
      else if (status_mask[k]) status_next[k] = next_status[k];
    end
    status_next[U_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_GPR; k++) gpr_q[k] <= '0;
      ir         <= '0;
      imm        <= '0;
      offset     <= '0;
      sp         <= SP_RESET;
      pc         <= PC_RESET;
      status     <= STATUS_RESET;
      page_cross <= 1'b0;
    end else if (stall) begin
      page_cross <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_GPR; k++) gpr_q[k] <= gpr_next[k];
      if (st_sel == ST_IR)  ir     <= data_in;
      if (st_sel == ST_IMM) imm    <= data_in;
      if (st_sel == ST_OFF) offset <= data_in;
      sp         <= sp_next;
      pc         <= pc_next;
      status     <= status_next;
      page_cross <= page_cross_next;
    end
  end

  byte_pair_reg #(.DATA_W(DATA_W)) u_ad (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .wr_lo   (st_sel == ST_ADL),
    .wr_hi   (st_sel == ST_ADH),
    .inc     (ad_inc),
    .clr_hi  (clr_adh),
    .data_in (data_in),
    .q       (ad)
  );

  byte_pair_reg #(.DATA_W(DATA_W)) u_ba (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .wr_lo   (st_sel == ST_BAL),
    .wr_hi   (st_sel == ST_BAH),
    .inc     (1'b0),
    .clr_hi  (clr_bah),
    .data_in (data_in),
    .q       (ba)
  );

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr_flat
    assign gpr[g*DATA_W +: DATA_W] = gpr_q[g];
  end

  assign stack_addr = {STACK_PAGE, sp};

  assign n = status[N_BIT];
  assign v = status[V_BIT];
  assign b = status[B_BIT];
  assign d = status[D_BIT];
  assign i = status[I_BIT];
  assign z = status[Z_BIT];
  assign c = status[C_BIT];

endmodule

// File: tb/tb_cpu_regfile_param.sv
// Bench for cpu_regfile_param: directed scenarios with literal expectations, then
// random traffic compared every cycle against an arithmetic reference model.
module tb_cpu_regfile_param;
  import cpu_regs_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [3:0]  st_sel;
  logic [1:0]  st_idx;
  logic [7:0]  data_in;
  logic        alu_we;
  logic [1:0]  alu_idx;
  logic [7:0]  alu_out;
  logic [1:0]  pc_op;
  logic [1:0]  sp_op;
  logic        ad_inc;
  logic        clr_adh;
  logic        clr_bah;
  logic [7:0]  next_status;
  logic [7:0]  status_mask;
  logic [23:0] gpr;
  logic [7:0]  ir, imm, offset, sp;
  logic [15:0] pc, ad, ba, stack_addr;
  logic [7:0]  status;
  logic        n, v, b, d, i, z, c;
  logic        page_cross;

  int checks = 0;
  int errors = 0;
  bit modelValid = 0;

  int mGpr[3];
  int mIr, mImm, mOff, mSp, mPc, mAd, mBa, mStatus;
  bit mPageCross;

  cpu_regfile_param dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .st_sel      (st_sel),
    .st_idx      (st_idx),
    .data_in     (data_in),
    .alu_we      (alu_we),
    .alu_idx     (alu_idx),
    .alu_out     (alu_out),
    .pc_op       (pc_op),
    .sp_op       (sp_op),
    .ad_inc      (ad_inc),
    .clr_adh     (clr_adh),
    .clr_bah     (clr_bah),
    .next_status (next_status),
    .status_mask (status_mask),
    .gpr         (gpr),
    .ir          (ir),
    .imm         (imm),
    .offset      (offset),
    .sp          (sp),
    .pc          (pc),
    .ad          (ad),
    .ba          (ba),
    .stack_addr  (stack_addr),
    .status      (status),
    .n           (n),
    .v           (v),
    .b           (b),
    .d           (d),
    .i           (i),
    .z           (z),
    .c           (c),
    .page_cross  (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    stall = 0; st_sel = ST_NONE; st_idx = 0; data_in = 0;
    alu_we = 0; alu_idx = 0; alu_out = 0; pc_op = PC_HOLD; sp_op = SP_HOLD;
    ad_inc = 0; clr_adh = 0; clr_bah = 0; next_status = 0; status_mask = 0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    clearInputs();
  endtask

  // Reference model: register contents as plain integers, updated from the rules each edge.
  always @(posedge clk) begin : model
    int nGpr[3];
    int nPc, nSp, nAd, nBa, nSt, lo, hi, soff;
    if (!rst) begin
      mGpr = '{0, 0, 0};
      mIr = 0; mImm = 0; mOff = 0; mAd = 0; mBa = 0;
      mSp = 'hFD; mPc = 'hFFFC; mStatus = 'h24; mPageCross = 0;
    end else if (stall) begin
      mPageCross = 0;
    end else begin
      nGpr = mGpr;
      if (st_sel == 1 && st_idx < 3) nGpr[st_idx] = data_in;
      if (alu_we && alu_idx < 3) nGpr[alu_idx] = alu_out;

      soff = (mOff >= 128) ? mOff - 256 : mOff;
      if (st_sel == 2 || st_sel == 3) begin
        lo = mPc % 256;
        hi = mPc / 256;
        if (pc_op == 1) lo = (lo + 1) % 256;
        else if (pc_op == 2) begin lo = mAd % 256; hi = mAd / 256; end
        else if (pc_op == 3) begin
          lo = (lo + mOff) % 256;
          hi = (hi + ((mOff >= 128) ? 255 : 0)) % 256;
        end
        if (st_sel == 2) hi = data_in; else lo = data_in;
        nPc = hi * 256 + lo;
      end else if (pc_op == 1) nPc = (mPc + 1) % 65536;
      else if (pc_op == 2) nPc = mAd;
      else if (pc_op == 3) nPc = (mPc + soff + 65536) % 65536;
      else nPc = mPc;
      mPageCross = (pc_op == 3) && (nPc / 256 != mPc / 256);

      if (sp_op == 1) nSp = (mSp + 255) % 256;
      else if (sp_op == 2) nSp = (mSp + 1) % 256;
      else if (sp_op == 3) nSp = data_in;
      else nSp = mSp;

      nAd = mAd;
      if (ad_inc) nAd = (nAd + 1) % 65536;
      if (st_sel == 5) nAd = (nAd / 256) * 256 + data_in;
      if (st_sel == 6) nAd = data_in * 256 + nAd % 256;
      if (clr_adh) nAd = nAd % 256;

      nBa = mBa;
      if (st_sel == 7) nBa = (nBa / 256) * 256 + data_in;
      if (st_sel == 8) nBa = data_in * 256 + nBa % 256;
      if (clr_bah) nBa = nBa % 256;

      nSt = 0;
      for (int k = 0; k < 8; k++) begin
        if (st_sel == 4 && k != 4 && k != 5) nSt += data_in[k] << k;
        else if (status_mask[k]) nSt += next_status[k] << k;
        else nSt += ((mStatus >> k) & 1) << k;
      end
      nSt = nSt | 'h20;

      if (st_sel == 9)  mIr  = data_in;
      if (st_sel == 10) mImm = data_in;
      if (st_sel == 11) mOff = data_in;
      mGpr = nGpr; mPc = nPc; mSp = nSp; mAd = nAd; mBa = nBa; mStatus = nSt;
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("gpr", {8'h0, gpr}, {8'h0, 8'(mGpr[2]), 8'(mGpr[1]), 8'(mGpr[0])});
      checkOutput("ir", {24'h0, ir}, 32'(mIr));
      checkOutput("imm", {24'h0, imm}, 32'(mImm));
      checkOutput("offset", {24'h0, offset}, 32'(mOff));
      checkOutput("sp", {24'h0, sp}, 32'(mSp));
      checkOutput("pc", {16'h0, pc}, 32'(mPc));
      checkOutput("ad", {16'h0, ad}, 32'(mAd));
      checkOutput("ba", {16'h0, ba}, 32'(mBa));
      checkOutput("stack_addr", {16'h0, stack_addr}, 32'('h100 + mSp));
      checkOutput("status", {24'h0, status}, 32'(mStatus));
      checkOutput("flags", {25'h0, n, v, b, d, i, z, c},
                  {25'h0, mStatus[7], mStatus[6], mStatus[4], mStatus[3], mStatus[2], mStatus[1], mStatus[0]});
      checkOutput("page_cross", {31'h0, page_cross}, {31'h0, mPageCross});
    end
  end

  initial begin
    rst = 0;
    clearInputs();
    applyStimulus(2);
    rst = 1;
    modelValid = 1;
    checkOutput("reset_pc", {16'h0, pc}, 32'hFFFC);
    checkOutput("reset_sp", {24'h0, sp}, 32'hFD);
    checkOutput("reset_status", {24'h0, status}, 32'h24);
    checkOutput("reset_gpr", {8'h0, gpr}, 32'h0);
    checkOutput("reset_ad_ba", {ad, ba}, 32'h0);
    checkOutput("model_reset_pc", 32'(mPc), 32'hFFFC);

    st_sel = ST_GPR; st_idx = 0; data_in = 8'hAA; applyStimulus(1);
    st_sel = ST_GPR; st_idx = 1; data_in = 8'hCC; applyStimulus(1);
    st_sel = ST_GPR; st_idx = 2; data_in = 8'hF0;
    alu_we = 1; alu_idx = 2; alu_out = 8'h55; applyStimulus(1);
    checkOutput("gpr_write", {8'h0, gpr}, 32'h55CCAA);
    checkOutput("model_gpr_y", 32'(mGpr[2]), 32'h55);

    st_sel = ST_PCH; data_in = 8'h12; applyStimulus(1);
    st_sel = ST_PCL; data_in = 8'hFF; applyStimulus(1);
    pc_op = PC_INC; applyStimulus(1);
    checkOutput("pc_inc_carry", {16'h0, pc}, 32'h1300);
    checkOutput("model_pc_inc", 32'(mPc), 32'h1300);
    st_sel = ST_OFF; data_in = 8'h80; applyStimulus(1);
    pc_op = PC_REL; applyStimulus(1);
    checkOutput("pc_rel_back", {16'h0, pc}, 32'h1280);
    checkOutput("page_cross_set", {31'h0, page_cross}, 32'h1);
    applyStimulus(1);
    checkOutput("page_cross_clear", {31'h0, page_cross}, 32'h0);

    sp_op = SP_LOAD; data_in = 8'h03; applyStimulus(1);
    checkOutput("stack_addr_load", {16'h0, stack_addr}, 32'h0103);
    repeat (7) begin sp_op = SP_PUSH; applyStimulus(1); end
    checkOutput("sp_push_wrap", {24'h0, sp}, 32'hFC);
    repeat (4) begin sp_op = SP_POP; applyStimulus(1); end
    checkOutput("sp_pop_wrap", {24'h0, sp}, 32'h00);
    checkOutput("stack_addr_pop", {16'h0, stack_addr}, 32'h0100);

    st_sel = ST_ADL; data_in = 8'hFF; applyStimulus(1);
    st_sel = ST_ADH; data_in = 8'h20; applyStimulus(1);
    ad_inc = 1; applyStimulus(1);
    checkOutput("ad_inc_carry", {16'h0, ad}, 32'h2100);
    clr_adh = 1; st_sel = ST_ADH; data_in = 8'h77; applyStimulus(1);
    checkOutput("ad_clear_wins", {16'h0, ad}, 32'h0000);

    next_status = 8'hC3; status_mask = 8'h83; applyStimulus(1);
    checkOutput("status_masked", {24'h0, status}, 32'hA7);
    checkOutput("flags_nzci", {28'h0, n, z, c, i}, 32'hF);
    checkOutput("model_status", 32'(mStatus), 32'hA7);
    st_sel = ST_P; data_in = 8'h00; next_status = 8'h10; status_mask = 8'h10; applyStimulus(1);
    checkOutput("status_stp_b", {24'h0, status}, 32'h30);
    stall = 1; st_sel = ST_GPR; st_idx = 0; data_in = 8'h11; pc_op = PC_INC; applyStimulus(3);
    checkOutput("stall_gpr", {8'h0, gpr}, 32'h55CCAA);
    checkOutput("stall_pc", {16'h0, pc}, 32'h1280);

    for (int t = 0; t < 800; t++) begin
      rst         = ($urandom_range(0, 59) != 0);
      stall       = ($urandom_range(0, 7) == 0);
      st_sel      = 4'($urandom_range(0, 15));
      st_idx      = 2'($urandom);
      data_in     = 8'($urandom);
      alu_we      = 1'($urandom);
      alu_idx     = 2'($urandom);
      alu_out     = 8'($urandom);
      pc_op       = 2'($urandom);
      sp_op       = 2'($urandom);
      ad_inc      = 1'($urandom);
      clr_adh     = ($urandom_range(0, 5) == 0);
      clr_bah     = ($urandom_range(0, 5) == 0);
      next_status = 8'($urandom);
      status_mask = 8'($urandom);
      applyStimulus(1);
    end
    rst = 1;
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
